ycr1_dmem_arb: RTL and testbench

YCR1_DMEM_ARB -- requirements
Module: ycr1_dmem_arb

---
 rtl/ycr1_dmem_arb_pkg.sv | 19 +
 rtl/ycr1_arb_sel.sv | 41 ++++
 rtl/ycr1_memif.svh | 20 ++
 rtl/ycr1_dmem_arb.sv | 136 +++++++++++++
 tb/tb_ycr1_dmem_arb.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ycr1_dmem_arb_pkg.sv
// Shared types for the two-master data-memory arbiter: FSM states and owner encoding.
// No logic; response encodings are re-exported from the memory interface header.
`include "ycr1_memif.svh"

package ycr1_dmem_arb_pkg;

    typedef enum logic {
        ARB_ADDR = 1'b0,
        ARB_DATA = 1'b1
    } type_ycr1_arb_fsm_e;

    localparam logic YCR1_ARB_OWNER_M0 = 1'b0;
    localparam logic YCR1_ARB_OWNER_M1 = 1'b1;

    localparam logic [1:0] YCR1_MEM_RESP_NOTRDY = `YCR1_MEM_RESP_NOTRDY;
    localparam logic [1:0] YCR1_MEM_RESP_RDY_OK = `YCR1_MEM_RESP_RDY_OK;
    localparam logic [1:0] YCR1_MEM_RESP_RDY_ER = `YCR1_MEM_RESP_RDY_ER;

endpackage

// File: rtl/ycr1_arb_sel.sv
// Two-way winner selection: pending lock, then sole requester, then burst limit, then priority.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the lock input keeps a stalled request granted until it is acked.
module ycr1_arb_sel
    import ycr1_dmem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       lock_vld,
    input  logic       lock_id,
    input  logic [3:0] burst_cnt,
    input  logic       burst_owner,
`ifdef YCR1_DMEM_ARB_RR_EN
    input  logic       rr_ptr,
`endif
    output logic       winner
);

    always_comb begin
        winner = YCR1_ARB_OWNER_M0;
        if (lock_vld) begin
            winner = lock_id;
        end else if (req0 & req1) begin
            // The burst cap only bites when both are asking; a sole requester is never starved.
            if (burst_cnt == 4'(BURST_MAX)) begin
                winner = ~burst_owner;
            end else begin
`ifdef YCR1_DMEM_ARB_RR_EN
                winner = rr_ptr;
`else
                winner = YCR1_ARB_OWNER_M0;
`endif
            end
        end else if (req1) begin
            winner = YCR1_ARB_OWNER_M1;
        end
    end

endmodule

// File: rtl/ycr1_memif.svh
// Data-memory interface encodings and bus widths shared by masters, arbiter and memory.
// Guarded so every file of the slice can include it independently.
`ifndef YCR1_MEMIF_SVH
`define YCR1_MEMIF_SVH

`define YCR1_DMEM_AWIDTH      32
`define YCR1_DMEM_DWIDTH      32

`define YCR1_MEM_CMD_RD       1'b0
`define YCR1_MEM_CMD_WR       1'b1

`define YCR1_MEM_WIDTH_BYTE   2'b00
`define YCR1_MEM_WIDTH_HWORD  2'b01
`define YCR1_MEM_WIDTH_WORD   2'b10

`define YCR1_MEM_RESP_NOTRDY  2'b00
`define YCR1_MEM_RESP_RDY_OK  2'b01
`define YCR1_MEM_RESP_RDY_ER  2'b10

`endif

// File: rtl/ycr1_dmem_arb.sv
// Two-master dmem arbiter, one outstanding transaction; round-robin with YCR1_DMEM_ARB_RR_EN, else m0 > m1.
// Latency: request routed combinationally in the issue window; response routed combinationally to the owner.
// Backpressure: an unacked forwarded request locks the grant; nothing issues while a response is NOTRDY/RDY_ER.
`include "ycr1_memif.svh"

module ycr1_dmem_arb
    import ycr1_dmem_arb_pkg::*;
#(
    parameter int YCR1_ARB_BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,

    input  logic                         m0_req,
    input  logic                         m0_cmd,
    input  logic [1:0]                   m0_width,
    input  logic [`YCR1_DMEM_AWIDTH-1:0] m0_addr,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] m0_wdata,
    output logic                         m0_req_ack,
    output logic [`YCR1_DMEM_DWIDTH-1:0] m0_rdata,
    output logic [1:0]                   m0_resp,

    input  logic                         m1_req,
    input  logic                         m1_cmd,
    input  logic [1:0]                   m1_width,
    input  logic [`YCR1_DMEM_AWIDTH-1:0] m1_addr,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] m1_wdata,
    output logic                         m1_req_ack,
    output logic [`YCR1_DMEM_DWIDTH-1:0] m1_rdata,
    output logic [1:0]                   m1_resp,

    output logic                         s_req,
    output logic                         s_cmd,
    output logic [1:0]                   s_width,
    output logic [`YCR1_DMEM_AWIDTH-1:0] s_addr,
    output logic [`YCR1_DMEM_DWIDTH-1:0] s_wdata,
    input  logic                         s_req_ack,
    input  logic [`YCR1_DMEM_DWIDTH-1:0] s_rdata,
    input  logic [1:0]                   s_resp,

    output logic                         arb_owner,
    output logic                         arb_busy
);

    type_ycr1_arb_fsm_e fsm;
    logic               owner_r;
    logic               lock_vld;
    logic               lock_id;
    logic [3:0]         burst_cnt;
    logic               en_r;
`ifdef YCR1_DMEM_ARB_RR_EN
    logic               rr_ptr;
`endif

    logic win_open;
    logic winner;
    logic win_req;
    logic issue;
    logic data_ph;

    ycr1_arb_sel #(
        .BURST_MAX   (YCR1_ARB_BURST_MAX)
    ) u_sel (
        .req0        (m0_req),
        .req1        (m1_req),
        .lock_vld    (lock_vld),
        .lock_id     (lock_id),
        .burst_cnt   (burst_cnt),
        .burst_owner (owner_r),
`ifdef YCR1_DMEM_ARB_RR_EN
        .rr_ptr      (rr_ptr),
`endif
        .winner      (winner)
    );

    // en_r keeps the shared port quiet in the first cycle after reset release.
    assign data_ph  = (fsm == ARB_DATA);
    assign win_open = en_r & (~data_ph | (s_resp == YCR1_MEM_RESP_RDY_OK));
    assign win_req  = winner ? m1_req : m0_req;
    assign issue    = s_req & s_req_ack;

    assign s_req    = win_open & win_req;
    assign s_cmd    = winner ? m1_cmd   : m0_cmd;
    assign s_width  = winner ? m1_width : m0_width;
    assign s_addr   = winner ? m1_addr  : m0_addr;
    assign s_wdata  = winner ? m1_wdata : m0_wdata;

    assign m0_req_ack = issue & (winner == YCR1_ARB_OWNER_M0);
    assign m1_req_ack = issue & (winner == YCR1_ARB_OWNER_M1);

    assign m0_resp  = (data_ph & (owner_r == YCR1_ARB_OWNER_M0)) ? s_resp  : YCR1_MEM_RESP_NOTRDY;
    assign m0_rdata = (data_ph & (owner_r == YCR1_ARB_OWNER_M0)) ? s_rdata : '0;
    assign m1_resp  = (data_ph & (owner_r == YCR1_ARB_OWNER_M1)) ? s_resp  : YCR1_MEM_RESP_NOTRDY;
    assign m1_rdata = (data_ph & (owner_r == YCR1_ARB_OWNER_M1)) ? s_rdata : '0;

    assign arb_owner = owner_r;
    assign arb_busy  = data_ph;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= ARB_ADDR;
            owner_r   <= YCR1_ARB_OWNER_M0;
            lock_vld  <= 1'b0;
            lock_id   <= YCR1_ARB_OWNER_M0;
            burst_cnt <= 4'd0;
            en_r      <= 1'b0;
`ifdef YCR1_DMEM_ARB_RR_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            en_r <= 1'b1;
            if (issue) begin
                fsm      <= ARB_DATA;
                owner_r  <= winner;
                lock_vld <= 1'b0;
                if (winner != owner_r) begin
                    burst_cnt <= 4'd1;
                end else if (burst_cnt != 4'(YCR1_ARB_BURST_MAX)) begin
                    burst_cnt <= burst_cnt + 4'd1;
                end
`ifdef YCR1_DMEM_ARB_RR_EN
                rr_ptr <= ~winner;
`endif
            end else begin
                if (s_req) begin
                    lock_vld <= 1'b1;
                    lock_id  <= winner;
                end
                if (data_ph && (s_resp != YCR1_MEM_RESP_NOTRDY)) begin
                    fsm <= ARB_ADDR;
                end
            end
        end
    end

endmodule

// File: tb/tb_ycr1_dmem_arb.sv
// Directed bench for ycr1_dmem_arb: reset, single read, contention, stall lock, error, back-to-back, mid-op reset.
`include "ycr1_memif.svh"

module tb_ycr1_dmem_arb;
    import ycr1_dmem_arb_pkg::*;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         m0_req, m0_cmd, m1_req, m1_cmd;
    logic [1:0]                   m0_width, m1_width;
    logic [`YCR1_DMEM_AWIDTH-1:0] m0_addr, m1_addr;
    logic [`YCR1_DMEM_DWIDTH-1:0] m0_wdata, m1_wdata;
    logic                         m0_req_ack, m1_req_ack;
    logic [`YCR1_DMEM_DWIDTH-1:0] m0_rdata, m1_rdata;
    logic [1:0]                   m0_resp, m1_resp;
    logic                         s_req, s_cmd, s_req_ack;
    logic [1:0]                   s_width, s_resp;
    logic [`YCR1_DMEM_AWIDTH-1:0] s_addr;
    logic [`YCR1_DMEM_DWIDTH-1:0] s_wdata, s_rdata;
    logic                         arb_owner, arb_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ycr1_dmem_arb #(.YCR1_ARB_BURST_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req     (m0_req),
        .m0_cmd     (m0_cmd),
        .m0_width   (m0_width),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_req_ack (m0_req_ack),
        .m0_rdata   (m0_rdata),
        .m0_resp    (m0_resp),
        .m1_req     (m1_req),
        .m1_cmd     (m1_cmd),
        .m1_width   (m1_width),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_req_ack (m1_req_ack),
        .m1_rdata   (m1_rdata),
        .m1_resp    (m1_resp),
        .s_req      (s_req),
        .s_cmd      (s_cmd),
        .s_width    (s_width),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_req_ack  (s_req_ack),
        .s_rdata    (s_rdata),
        .s_resp     (s_resp),
        .arb_owner  (arb_owner),
        .arb_busy   (arb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_cmd = `YCR1_MEM_CMD_RD; m0_width = `YCR1_MEM_WIDTH_WORD; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_cmd = `YCR1_MEM_CMD_RD; m1_width = `YCR1_MEM_WIDTH_WORD; m1_addr = '0; m1_wdata = '0;
        s_req_ack = 0; s_rdata = '0; s_resp = `YCR1_MEM_RESP_NOTRDY;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();
    endtask

    initial begin
        logic exp_win [10];

        // Reset state, with a master already requesting and the slave acking.
        idle_inputs();
        rst_n = 0;
        m0_req = 1; s_req_ack = 1;
        #3;
        chk("rst_s_req", s_req, 0);
        chk("rst_m0_ack", m0_req_ack, 0);
        chk("rst_m0_resp", m0_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("rst_busy", arb_busy, 0);
        chk("rst_owner", arb_owner, 0);
        cyc();
        rst_n = 1;
        @(negedge clk);
        chk("post_rst_s_req", s_req, 0);
        chk("post_rst_m0_ack", m0_req_ack, 0);
        do_reset();

        // Single m0 read, ack in cycle 0, RDY_OK in cycle 2.
        m0_req = 1; m0_cmd = `YCR1_MEM_CMD_RD; m0_addr = 32'h0001_0000; s_req_ack = 1;
        @(negedge clk);
        chk("rd_s_req", s_req, 1);
        chk("rd_s_addr", s_addr, 32'h0001_0000);
        chk("rd_s_cmd", s_cmd, `YCR1_MEM_CMD_RD);
        chk("rd_m0_ack", m0_req_ack, 1);
        chk("rd_m1_ack", m1_req_ack, 0);
        chk("rd_m1_resp0", m1_resp, `YCR1_MEM_RESP_NOTRDY);
        cyc();
        m0_req = 0; s_req_ack = 0;
        @(negedge clk);
        chk("rd_busy1", arb_busy, 1);
        chk("rd_m0_resp1", m0_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("rd_s_req1", s_req, 0);
        cyc();
        s_resp = `YCR1_MEM_RESP_RDY_OK; s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_m0_resp2", m0_resp, `YCR1_MEM_RESP_RDY_OK);
        chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_resp2", m1_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("rd_m1_rdata", m1_rdata, 0);
        cyc();
        s_resp = `YCR1_MEM_RESP_NOTRDY;
        @(negedge clk);
        chk("rd_busy3", arb_busy, 0);

        // Simultaneous requests, slave always acks and always answers RDY_OK.
`ifdef YCR1_DMEM_ARB_RR_EN
        exp_win = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_win = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        do_reset();
        m0_req = 1; m0_addr = 32'h100; m1_req = 1; m1_addr = 32'h200; s_req_ack = 1;
        for (int i = 0; i < 10; i++) begin
            s_resp = (i == 0) ? `YCR1_MEM_RESP_NOTRDY : `YCR1_MEM_RESP_RDY_OK;
            @(negedge clk);
            chk($sformatf("arb_m0_ack[%0d]", i), m0_req_ack, !exp_win[i]);
            chk($sformatf("arb_m1_ack[%0d]", i), m1_req_ack, exp_win[i]);
            chk($sformatf("arb_addr[%0d]", i), s_addr, exp_win[i] ? 32'h200 : 32'h100);
            if (i > 0) chk($sformatf("arb_owner[%0d]", i), arb_owner, exp_win[i-1]);
            cyc();
        end

        // m1 stalls for 3 cycles; m0 arrives during the stall and must not steal the grant.
        do_reset();
        m1_req = 1; m1_addr = 32'h0000_2000; m0_addr = 32'h0000_1000;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) m0_req = 1;
            s_req_ack = (i == 3);
            @(negedge clk);
            chk($sformatf("stall_s_req[%0d]", i), s_req, 1);
            chk($sformatf("stall_addr[%0d]", i), s_addr, 32'h0000_2000);
            chk($sformatf("stall_m0_ack[%0d]", i), m0_req_ack, 0);
            chk($sformatf("stall_m1_ack[%0d]", i), m1_req_ack, (i == 3));
            cyc();
        end
        m1_req = 0; s_req_ack = 0;
        @(negedge clk);
        chk("wait_s_req", s_req, 0);
        chk("wait_owner", arb_owner, 1);

        // m1 gets RDY_ER while m0 is waiting: nothing issues that cycle, m0 wins next from ARB_ADDR.
        cyc();
        s_resp = `YCR1_MEM_RESP_RDY_ER; s_rdata = 32'h1234_5678; s_req_ack = 1;
        @(negedge clk);
        chk("er_m1_resp", m1_resp, `YCR1_MEM_RESP_RDY_ER);
        chk("er_m0_resp", m0_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("er_s_req", s_req, 0);
        chk("er_m0_ack", m0_req_ack, 0);
        cyc();
        s_resp = `YCR1_MEM_RESP_NOTRDY;
        @(negedge clk);
        chk("er_busy_next", arb_busy, 0);
        chk("er_m0_ack_next", m0_req_ack, 1);
        chk("er_addr_next", s_addr, 32'h0000_1000);
        cyc();
        m0_req = 0; s_req_ack = 0;
        @(negedge clk);
        chk("er_owner_next", arb_owner, 0);

        // Back-to-back writes: new ack alongside RDY_OK keeps ARB_DATA without a bubble.
        do_reset();
        m0_req = 1; m0_cmd = `YCR1_MEM_CMD_WR; m0_addr = 32'h3000; m0_wdata = 32'hAAAA_AAAA; s_req_ack = 1;
        @(negedge clk);
        chk("b2b_s_cmd", s_cmd, `YCR1_MEM_CMD_WR);
        chk("b2b_s_wdata0", s_wdata, 32'hAAAA_AAAA);
        cyc();
        m0_addr = 32'h3004; m0_wdata = 32'hBBBB_BBBB; s_resp = `YCR1_MEM_RESP_RDY_OK;
        @(negedge clk);
        chk("b2b_s_req1", s_req, 1);
        chk("b2b_m0_ack1", m0_req_ack, 1);
        chk("b2b_s_wdata1", s_wdata, 32'hBBBB_BBBB);
        chk("b2b_m0_resp1", m0_resp, `YCR1_MEM_RESP_RDY_OK);
        cyc();
        m0_req = 0; m1_req = 1; m1_cmd = `YCR1_MEM_CMD_WR; m1_addr = 32'h4000; m1_wdata = 32'hCCCC_CCCC;
        @(negedge clk);
        chk("b2b_busy2", arb_busy, 1);
        chk("b2b_owner2", arb_owner, 0);
        chk("b2b_m1_ack2", m1_req_ack, 1);
        chk("b2b_s_wdata2", s_wdata, 32'hCCCC_CCCC);
        cyc();
        m1_req = 0; s_req_ack = 0; s_resp = `YCR1_MEM_RESP_NOTRDY;
        @(negedge clk);
        chk("b2b_owner3", arb_owner, 1);
        chk("b2b_busy3", arb_busy, 1);

        // Reset while m1's response is pending; the late RDY_OK must go nowhere.
        cyc();
        m0_req = 1; s_resp = `YCR1_MEM_RESP_RDY_OK; s_rdata = 32'h5555_5555; s_req_ack = 1;
        rst_n = 0;
        #1;
        chk("mrst_busy", arb_busy, 0);
        chk("mrst_owner", arb_owner, 0);
        chk("mrst_s_req", s_req, 0);
        chk("mrst_m1_resp", m1_resp, `YCR1_MEM_RESP_NOTRDY);
        cyc();
        rst_n = 1; m0_req = 0; s_req_ack = 0;
        @(negedge clk);
        chk("late_m1_resp", m1_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("late_m1_rdata", m1_rdata, 0);
        chk("late_m0_resp", m0_resp, `YCR1_MEM_RESP_NOTRDY);
        chk("late_busy", arb_busy, 0);
        cyc();
        @(negedge clk);
        chk("late_busy2", arb_busy, 0);
        chk("late_m0_rdata", m0_rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
